display_7seg_scan_n: RTL and testbench
======================================

Name: display_7seg_scan_n

Overview:
- Parametrised N-digit multiplexed 7-segment driver: time-multiplexes N hex digits onto one shared segment bus plus N anode enables.
- Adds double-buffered loading (tear-free), hex decoding 0-F, leading-zero blanking, decimal points, inter-digit dead time and 8-level brightness PWM.
- Sits between the BCD/hex datapath and board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; must be ≥1; digit N_DIGITS-1 is most significant.
- REFRESH_CYCLES, 27000, clock cycles per digit slot; must be ≥ DEAD_CYCLES+8.
- DEAD_CYCLES, 2, cycles at slot start with all anodes inactive (anti-ghosting).
- ANODE_ACTIVE_LOW, 1, 1 means an active anode drives 0.
- SEG_ACTIVE_LOW, 1, 1 means a lit segment and the dp drive 0.
- BLANK_LEADING_ZEROS, 1, 1 enables leading-zero suppression.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- digits_i  in  4*N_DIGITS  hex nibbles; [3:0] is digit 0.
- dp_i  in  N_DIGITS  decimal point per digit.
- load_i  in  1  capture digits_i/dp_i into shadow register.
- brightness_i  in  3  0 = dimmest, 7 = full.
- anodo_o  out  N_DIGITS  anode enables, one-hot active when lit.
- catodo_o  out  7  segments; bit0=a … bit6=g.
- dp_o  out  1  decimal point of the digit currently shown.
- frame_o  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset (synchronous, rst_i=1):
  - Shadow and active registers = 0; digit index = 0; elapsed-in-slot e = 0.
  - anodo_o all inactive; catodo_o all unlit; dp_o unlit; frame_o = 0.
  - Reset mid-scan aborts the slot immediately; the next cycle follows the reset values.
- Shadow register:
  - When load_i=1, digits_i/dp_i are captured at the clock edge.
  - Shadow copies to the active register only at the frame wrap.
  - If load_i is high on the wrap cycle, the active register takes the pre-edge shadow. The new value appears one frame later.
- Slot counter:
  - e counts 0..REFRESH_CYCLES-1 and wraps to 0.
  - On wrap, digit index increments modulo N_DIGITS.
  - On index N_DIGITS-1→0: frame_o pulses for 1 cycle and the active register updates. frame_o fires on the first cycle of the digit-0 slot, registered.
  - N_DIGITS=1: index stays 0; frame_o pulses every slot.
- Brightness:
  - brightness_i is sampled when e=0 and held for the slot.
  - W = REFRESH_CYCLES-DEAD_CYCLES; chunk = floor(W/8).
  - on_len = (b+1)*chunk for b<7; on_len = W for b=7.
- Anode:
  - The indexed anode is active iff DEAD_CYCLES ≤ e < DEAD_CYCLES+on_len.
  - Otherwise all anodes are inactive.
- Decode:
  - Standard hex patterns (active-high g..a):
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111
    - 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1101111, A=1110111, b=1111100
    - C=0111001, d=1011110, E=1111001, F=1110001
  - Polarity is applied after decode.
- Leading-zero blanking:
  - Digit i>0 is blanked when its nibble and every higher nibble are 0 and BLANK_LEADING_ZEROS=1.
  - Digit 0 is never blanked.
  - Blanking forces segments unlit. The anode still scans. dp still follows dp_i.
- Latency: all outputs are registered, 1 cycle after the internal counter/index state. The active-register value drives catodo_o/dp_o during the whole slot, including dead time.

Test Plan (N_DIGITS=4, REFRESH_CYCLES=16, DEAD_CYCLES=2, active-low both):
- Reset held 3 cycles then released → anodo_o=4'b1111, catodo_o=7'b1111111, dp_o=1 during reset. First frame_o pulse occurs 64 cycles after the wrap following release. Digit order is 0,1,2,3.
- load_i pulse with digits_i=16'h1A3F, brightness=7 → after next frame_o:
  - digit0 (anodo_o=1110) catodo_o=0001110
  - digit1 0110000
  - digit2 0001000
  - digit3 1111001
  - Each anode is low exactly 14 cycles per 16-cycle slot.
- digits_i=16'h0005, LZB=1:
  - digits 3..1 show 1111111 while their anodes scan; digit0 shows 0010010.
  - digits_i=16'h0000: only digit0 lit with 1000000.
  - digits_i=16'h0100: digit1 and digit2 lit.
- brightness_i=0 → each anode low 1 cycle (e=2) per slot. brightness_i=3 → 4 cycles (e=2..5). A change mid-slot takes effect at the next slot.
- load 16'h1234 then, mid-frame, load 16'h5678 → 1234 is shown for the full frame; 5678 appears only after the next frame_o. A load coincident with frame_o appears one frame later.
- dp_i=4'b0100 loaded → dp_o=0 only while digit2 is selected. rst_i asserted mid-slot of digit2 → next cycle all outputs inactive, index 0, active value 0.

Source files
------------

// File: rtl/display_7seg_scan_n.sv
// Multiplexed N-digit 7-segment driver with a shadow/active digit buffer, leading-zero
// blanking, anti-ghosting dead time and 8-level PWM brightness. All pin outputs are registered.
module display_7seg_scan_n #(
  parameter int N_DIGITS            = 4,
  parameter int REFRESH_CYCLES      = 27000,
  parameter int DEAD_CYCLES         = 2,
  parameter bit ANODE_ACTIVE_LOW    = 1'b1,
  parameter bit SEG_ACTIVE_LOW      = 1'b1,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  input  logic [2:0]            brightness_i,
  output logic [N_DIGITS-1:0]   anodo_o,
  output logic [6:0]            catodo_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int E_W   = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int ON_W  = REFRESH_CYCLES - DEAD_CYCLES;
  localparam int CHUNK = ON_W / 8;

  logic [E_W-1:0]          e_q, e_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [2:0]              bright_q, bright_d;
  logic [4*N_DIGITS-1:0]   shadow_dig_q, shadow_dig_d;
  logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*N_DIGITS-1:0]   active_dig_q, active_dig_d;
  logic [N_DIGITS-1:0]     active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]     anodo_q, anodo_d;
  logic [6:0]              catodo_q, catodo_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [2:0]              bright_eff;
  logic [31:0]             on_len;
  logic [31:0]             e_ext;
  logic                    lit;

  logic [N_DIGITS-1:0]     blank;
  logic [N_DIGITS-1:0]     onehot;
  logic                    zero_above;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              seg_raw;
  logic [6:0]              seg_lit;

  // Slot timing, buffer transfer and the PWM window for the current slot.
  always_comb begin
    slot_end   = (e_q == E_W'(REFRESH_CYCLES - 1));
    frame_wrap = slot_end && (idx_q == IDX_W'(N_DIGITS - 1));

    e_d   = slot_end ? '0 : e_q + E_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
    end

    bright_eff = (e_q == '0) ? brightness_i : bright_q;
    bright_d   = bright_eff;

    shadow_dig_d = load_i ? digits_i : shadow_dig_q;
    shadow_dp_d  = load_i ? dp_i : shadow_dp_q;
    active_dig_d = frame_wrap ? shadow_dig_q : active_dig_q;
    active_dp_d  = frame_wrap ? shadow_dp_q : active_dp_q;

    on_len = (bright_eff == 3'd7) ? 32'(ON_W) : (32'(bright_eff) + 32'd1) * 32'(CHUNK);
    e_ext  = 32'(e_q);
    lit    = (e_ext >= 32'(DEAD_CYCLES)) && (e_ext < 32'(DEAD_CYCLES) + on_len);
    frame_d = frame_wrap;
  end

  // Digit selection, blanking from the top digit downwards, then hex decode.
  always_comb begin
    blank      = '0;
    onehot     = '0;
    zero_above = 1'b1;
    cur_nib    = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_dig_q[i*4 +: 4] == 4'd0);
      blank[i]   = BLANK_LEADING_ZEROS && (i > 0) && zero_above;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = active_dig_q[i*4 +: 4];
        cur_dp    = active_dp_q[i];
        cur_blank = blank[i];
        onehot[i] = lit;
      end
    end

    case (cur_nib)
      4'h0:    seg_raw = 7'b0111111;
      4'h1:    seg_raw = 7'b0000110;
      4'h2:    seg_raw = 7'b1011011;
      4'h3:    seg_raw = 7'b1001111;
      4'h4:    seg_raw = 7'b1100110;
      4'h5:    seg_raw = 7'b1101101;
      4'h6:    seg_raw = 7'b1111101;
      4'h7:    seg_raw = 7'b0000111;
      4'h8:    seg_raw = 7'b1111111;
      4'h9:    seg_raw = 7'b1101111;
      4'hA:    seg_raw = 7'b1110111;
      4'hB:    seg_raw = 7'b1111100;
      4'hC:    seg_raw = 7'b0111001;
      4'hD:    seg_raw = 7'b1011110;
      4'hE:    seg_raw = 7'b1111001;
      default: seg_raw = 7'b1110001;
    endcase
    seg_lit = cur_blank ? 7'b0000000 : seg_raw;

    catodo_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_d     = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
    anodo_d  = ANODE_ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q          <= '0;
      idx_q        <= '0;
      bright_q     <= 3'd0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      active_dig_q <= '0;
      active_dp_q  <= '0;
      anodo_q      <= {N_DIGITS{ANODE_ACTIVE_LOW}};
      catodo_q     <= {7{SEG_ACTIVE_LOW}};
      dp_q         <= SEG_ACTIVE_LOW;
      frame_q      <= 1'b0;
    end else begin
      e_q          <= e_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      active_dig_q <= active_dig_d;
      active_dp_q  <= active_dp_d;
      anodo_q      <= anodo_d;
      catodo_q     <= catodo_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign anodo_o  = anodo_q;
  assign catodo_o = catodo_q;
  assign dp_o     = dp_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_display_7seg_scan_n.sv
// Directed bench for display_7seg_scan_n with 4 digits, 16-cycle slots, 2 dead cycles,
// active-low anodes and segments; every expected pattern is hand-computed.
module tb_display_7seg_scan_n;

  localparam int N = 4;
  localparam int R = 16;
  localparam int D = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic [2:0]  brightness_i;
  logic [3:0]  anodo_o;
  logic [6:0]  catodo_o;
  logic        dp_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  display_7seg_scan_n #(
    .N_DIGITS(N), .REFRESH_CYCLES(R), .DEAD_CYCLES(D),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZEROS(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .digits_i(digits_i), .dp_i(dp_i),
    .load_i(load_i), .brightness_i(brightness_i), .anodo_o(anodo_o),
    .catodo_o(catodo_o), .dp_o(dp_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] dig, input logic [3:0] dp,
                               input logic ld, input logic [2:0] br);
    digits_i     = dig;
    dp_i         = dp;
    load_i       = ld;
    brightness_i = br;
  endtask

  // Counts negedges from a reset release until frame_o; a frame arrives 64 cycles later.
  task automatic countToFrame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (frame_o !== 1'b1 && n < 200);
    checkOutput(tag, 32'(n), 32'd64);
  endtask

  // Called on the negedge where frame_o is high; observes the following 64 cycles,
  // which show digit slots 0..3 of the frame that just started.
  task automatic scanFrame(input int id, input int load_step, input logic [15:0] ld_dig,
                           input logic [3:0] ld_dp, input int b_step, input logic [2:0] b_val,
                           input logic [27:0] exp_seg, input logic [19:0] exp_lit,
                           input logic [3:0] exp_dp);
    int          lit_cnt [4];
    int          first   [4];
    logic [6:0]  seg     [4];
    logic        dpv     [4];
    int          bad;
    int          fbad;
    int          d;
    int          e;
    logic [3:0]  want_an;
    bad  = 0;
    fbad = 0;
    for (int k = 0; k < 4; k++) begin
      lit_cnt[k] = 0;
      first[k]   = -1;
      seg[k]     = 7'h00;
      dpv[k]     = 1'b0;
    end
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk_i);
      d = (j - 1) / R;
      e = (j - 1) % R;
      if (e == 0) begin
        seg[d] = catodo_o;
        dpv[d] = dp_o;
      end else if (catodo_o !== seg[d] || dp_o !== dpv[d]) begin
        bad++;
      end
      want_an = ~(4'b0001 << d);
      if (anodo_o === want_an) begin
        lit_cnt[d]++;
        if (first[d] < 0) first[d] = e;
      end else if (anodo_o !== 4'hF) begin
        bad++;
      end
      if (frame_o !== (j == 64)) fbad++;
      if (j == load_step) applyStimulus(ld_dig, ld_dp, 1'b1, brightness_i);
      else if (load_i) applyStimulus(digits_i, dp_i, 1'b0, brightness_i);
      if (j == b_step) applyStimulus(digits_i, dp_i, load_i, b_val);
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("scan%0d_d%0d_seg", id, k), 32'(seg[k]), 32'(exp_seg[k*7 +: 7]));
      checkOutput($sformatf("scan%0d_d%0d_litcycles", id, k), 32'(lit_cnt[k]), 32'(exp_lit[k*5 +: 5]));
      checkOutput($sformatf("scan%0d_d%0d_firstlit_e", id, k), 32'(first[k]), 32'(D));
      checkOutput($sformatf("scan%0d_d%0d_dp", id, k), 32'(dpv[k]), 32'(exp_dp[k]));
    end
    checkOutput($sformatf("scan%0d_illegal_or_unstable", id), 32'(bad), 32'd0);
    checkOutput($sformatf("scan%0d_frame_pulse", id), 32'(fbad), 32'd0);
  endtask

  localparam logic [27:0] SEG_ZERO = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [27:0] SEG_1A3F = {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110};
  localparam logic [27:0] SEG_0005 = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010};
  localparam logic [27:0] SEG_0100 = {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000};
  localparam logic [27:0] SEG_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] SEG_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [27:0] SEG_9ABC = {7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110};
  localparam logic [19:0] LIT_FULL = {5'd14, 5'd14, 5'd14, 5'd14};
  localparam logic [19:0] LIT_MIN  = {5'd1, 5'd1, 5'd1, 5'd1};
  localparam logic [19:0] LIT_MIX  = {5'd4, 5'd4, 5'd4, 5'd1};

  initial begin
    rst_i = 1'b1;
    applyStimulus(16'h0000, 4'b0000, 1'b0, 3'd7);
    repeat (3) @(negedge clk_i);
    checkOutput("rst_anodo", 32'(anodo_o), 32'hF);
    checkOutput("rst_catodo", 32'(catodo_o), 32'h7F);
    checkOutput("rst_dp", 32'(dp_o), 32'd1);
    checkOutput("rst_frame", 32'(frame_o), 32'd0);
    rst_i = 1'b0;
    countToFrame("first_frame_latency");

    scanFrame(1, 5, 16'h1A3F, 4'b0000, -1, 3'd7, SEG_ZERO, LIT_FULL, 4'b1111);
    scanFrame(2, 5, 16'h0005, 4'b0000, -1, 3'd7, SEG_1A3F, LIT_FULL, 4'b1111);
    scanFrame(3, 5, 16'h0000, 4'b0000, -1, 3'd7, SEG_0005, LIT_FULL, 4'b1111);
    scanFrame(4, 5, 16'h0100, 4'b0000, -1, 3'd7, SEG_ZERO, LIT_FULL, 4'b1111);
    applyStimulus(digits_i, dp_i, 1'b0, 3'd0);
    scanFrame(5, 5, 16'h1234, 4'b0000, -1, 3'd0, SEG_0100, LIT_MIN, 4'b1111);
    scanFrame(6, 30, 16'h5678, 4'b0000, 8, 3'd3, SEG_1234, LIT_MIX, 4'b1111);
    applyStimulus(digits_i, dp_i, 1'b0, 3'd7);
    scanFrame(7, 63, 16'h9ABC, 4'b0100, -1, 3'd7, SEG_5678, LIT_FULL, 4'b1111);
    scanFrame(8, -1, 16'h0000, 4'b0000, -1, 3'd7, SEG_5678, LIT_FULL, 4'b1111);
    scanFrame(9, -1, 16'h0000, 4'b0000, -1, 3'd7, SEG_9ABC, LIT_FULL, 4'b1011);

    repeat (37) @(negedge clk_i);
    checkOutput("pre_reset_digit2_anodo", 32'(anodo_o), 32'b1011);
    checkOutput("pre_reset_digit2_dp", 32'(dp_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midslot_rst_anodo", 32'(anodo_o), 32'hF);
    checkOutput("midslot_rst_catodo", 32'(catodo_o), 32'h7F);
    checkOutput("midslot_rst_dp", 32'(dp_o), 32'd1);
    checkOutput("midslot_rst_frame", 32'(frame_o), 32'd0);
    rst_i = 1'b0;
    countToFrame("post_reset_frame_latency");
    scanFrame(10, -1, 16'h0000, 4'b0000, -1, 3'd7, SEG_ZERO, LIT_FULL, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
